pc_sequencer: RTL and testbench

- Parametrised program-counter sequencer; successor to the fixed 8-bit inverted-clock PC with flag-select jump.
- Generates the instruction address every cycle; supports:
  - sequential increment
  - unconditional jump
  - flag-conditional jump with selectable polarity
  - call/return through an internal hardware return stack
  - halt
- Sits between the control decoder (OP, TARGET, FSEL, FPOL) and the flags register (FLAGS); ADDR feeds instruction memory.

---
 rtl/pc_sequencer.sv | 154 +++++++++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised program-counter sequencer with flag-conditional
// jumps, call/return through an internal LIFO return stack, and halt.
module pc_sequencer #(
  parameter int unsigned    AW         = 8,
  parameter int unsigned    FW         = 8,
  parameter int unsigned    SD         = 4,
  parameter logic [AW-1:0]  RESET_ADDR = '0,
  localparam int unsigned   FSW        = (FW > 1) ? $clog2(FW) : 1,
  localparam int unsigned   SPW        = $clog2(SD + 1)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           EN,
  input  logic [2:0]     OP,
  input  logic [AW-1:0]  TARGET,
  input  logic [FW-1:0]  FLAGS,
  input  logic [FSW-1:0] FSEL,
  input  logic           FPOL,
  output logic [AW-1:0]  ADDR,
  output logic [SPW-1:0] SP,
  output logic           TAKEN,
  output logic           HALTED,
  output logic           STK_OVF,
  output logic           STK_UNF
);

  localparam int unsigned SIW = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic [2:0] {
    OP_SEQ   = 3'b000,
    OP_JMP   = 3'b001,
    OP_JCC   = 3'b010,
    OP_CALL  = 3'b011,
    OP_RET   = 3'b100,
    OP_CCALL = 3'b101,
    OP_CRET  = 3'b110,
    OP_HALT  = 3'b111
  } op_e;

  logic [AW-1:0]  addr_q, addr_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           taken_q, taken_d;
  logic           halted_q, halted_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [AW-1:0]  stack_q [SD];

  logic           step;
  logic           cond;
  logic           flag_bit;
  logic           push_en;
  logic [AW-1:0]  inc;
  op_e            op;

  assign op   = op_e'(OP);
  assign step = EN & ~halted_q;
  assign inc  = addr_q + 1'b1;

  // Select the condition flag; out-of-range selects read as 0.
  always_comb begin
    flag_bit = 1'b0;
    if (32'(FSEL) < FW) flag_bit = FLAGS[FSEL];
    cond = (flag_bit == FPOL);
  end

  // Next-state decode for address, stack pointer and status flags.
  always_comb begin
    addr_d   = addr_q;
    sp_d     = sp_q;
    taken_d  = taken_q;
    halted_d = halted_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push_en  = 1'b0;
    if (step) begin
      addr_d  = inc;
      taken_d = 1'b0;
      unique case (op)
        OP_SEQ: ;
        OP_JMP: begin
          addr_d  = TARGET;
          taken_d = 1'b1;
        end
        OP_JCC: begin
          if (cond) begin
            addr_d  = TARGET;
            taken_d = 1'b1;
          end
        end
        // Conditional variants fall back to SEQ when cond is false.
        OP_CALL, OP_CCALL: begin
          if (op == OP_CALL || cond) begin
            if (sp_q < SPW'(SD)) begin
              push_en = 1'b1;
              sp_d    = sp_q + 1'b1;
              addr_d  = TARGET;
              taken_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        OP_RET, OP_CRET: begin
          if (op == OP_RET || cond) begin
            if (sp_q != '0) begin
              sp_d    = sp_q - 1'b1;
              addr_d  = stack_q[SIW'(sp_q - 1'b1)];
              taken_d = 1'b1;
            end else begin
              unf_d = 1'b1;
            end
          end
        end
        OP_HALT: begin
          addr_d   = addr_q;
          halted_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      addr_q   <= RESET_ADDR;
      sp_q     <= '0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      sp_q     <= sp_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Return stack storage; contents need no reset.
  always_ff @(posedge CLK) begin
    if (RST_N && push_en) stack_q[SIW'(sp_q)] <= inc;
  end

  assign ADDR    = addr_q;
  assign SP      = sp_q;
  assign TAKEN   = taken_q;
  assign HALTED  = halted_q;
  assign STK_OVF = ovf_q;
  assign STK_UNF = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios then randomized steps,
// all checked against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int unsigned AW = 8;
  localparam int unsigned FW = 8;
  localparam int unsigned SD = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          EN;
  logic [2:0]    OP;
  logic [AW-1:0] TARGET;
  logic [FW-1:0] FLAGS;
  logic [2:0]    FSEL;
  logic          FPOL;
  logic [AW-1:0] ADDR;
  logic [2:0]    SP;
  logic          TAKEN, HALTED, STK_OVF, STK_UNF;

  int tests  = 0;
  int failed = 0;

  // Reference model state
  int m_addr;
  int m_stack[$];
  bit m_taken, m_halt, m_ovf, m_unf;

  pc_sequencer #(.AW(AW), .FW(FW), .SD(SD), .RESET_ADDR(8'h00)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .OP(OP), .TARGET(TARGET),
    .FLAGS(FLAGS), .FSEL(FSEL), .FPOL(FPOL), .ADDR(ADDR), .SP(SP),
    .TAKEN(TAKEN), .HALTED(HALTED), .STK_OVF(STK_OVF), .STK_UNF(STK_UNF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},   32'(ADDR),    32'(m_addr));
    check({tag, ".sp"},     32'(SP),      32'(m_stack.size()));
    check({tag, ".taken"},  32'(TAKEN),   32'(m_taken));
    check({tag, ".halted"}, 32'(HALTED),  32'(m_halt));
    check({tag, ".ovf"},    32'(STK_OVF), 32'(m_ovf));
    check({tag, ".unf"},    32'(STK_UNF), 32'(m_unf));
  endtask

  // Behavioural model of one rising edge.
  task automatic model(input bit rst_n, input bit en, input int op, input int tgt,
                       input int flags, input int fsel, input bit fpol);
    int  nxt;
    bit  c, do_call, do_ret;
    if (!rst_n) begin
      m_addr = 0; m_stack.delete(); m_taken = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    if (!en || m_halt) return;
    nxt = (m_addr + 1) % (1 << AW);
    c = (fsel < FW) ? (((flags >> fsel) & 1) == fpol) : (fpol == 0);
    do_call = (op == 3) || (op == 5 && c);
    do_ret  = (op == 4) || (op == 6 && c);
    m_taken = 0;
    if (op == 7) begin
      m_halt = 1;
    end else if (op == 1 || (op == 2 && c)) begin
      m_addr = tgt; m_taken = 1;
    end else if (do_call) begin
      if (m_stack.size() < SD) begin
        m_stack.push_back(nxt); m_addr = tgt; m_taken = 1;
      end else begin
        m_ovf = 1; m_addr = nxt;
      end
    end else if (do_ret) begin
      if (m_stack.size() > 0) begin
        m_addr = m_stack.pop_back(); m_taken = 1;
      end else begin
        m_unf = 1; m_addr = nxt;
      end
    end else begin
      m_addr = nxt;
    end
  endtask

  task automatic step(input string tag, input bit rst_n, input bit en, input int op,
                      input int tgt, input int flags, input int fsel, input bit fpol);
    RST_N = rst_n; EN = en; OP = 3'(op); TARGET = AW'(tgt);
    FLAGS = FW'(flags); FSEL = 3'(fsel); FPOL = fpol;
    @(posedge CLK);
    #1;
    model(rst_n, en, op, tgt, flags, fsel, fpol);
    check_all(tag);
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; OP = '0; TARGET = '0; FLAGS = '0; FSEL = '0; FPOL = 1'b0;

    step("reset", 0, 0, 0, 0, 0, 0, 0);
    check("reset.addr0", 32'(ADDR), 32'h0);

    for (int i = 1; i <= 3; i++) begin
      step("seq", 1, 1, 0, 0, 0, 0, 0);
      check("seq.addr_const", 32'(ADDR), 32'(i));
    end

    // JCC taken / not taken from 0x05
    step("jmp05", 1, 1, 1, 8'h05, 0, 0, 0);
    step("jcc_t", 1, 1, 2, 8'h40, 8'h08, 3, 1);
    check("jcc_t.addr_const", 32'(ADDR), 32'h40);
    step("jmp05b", 1, 1, 1, 8'h05, 0, 0, 0);
    step("jcc_n", 1, 1, 2, 8'h40, 8'h00, 3, 1);
    check("jcc_n.addr_const", 32'(ADDR), 32'h06);

    // CALL / SEQ / RET from 0x10
    step("jmp10", 1, 1, 1, 8'h10, 0, 0, 0);
    step("call",  1, 1, 3, 8'h80, 0, 0, 0);
    step("cseq",  1, 1, 0, 0, 0, 0, 0);
    step("ret",   1, 1, 4, 0, 0, 0, 0);
    check("ret.addr_const", 32'(ADDR), 32'h11);

    // Overflow and underflow from ADDR=0
    step("rst2", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("call5", 1, 1, 3, 8'h20, 0, 0, 0);
    check("ovf.addr_const", 32'(ADDR), 32'h21);
    check("ovf.flag_const", 32'(STK_OVF), 32'h1);
    for (int i = 0; i < 5; i++) step("ret5", 1, 1, 4, 0, 0, 0, 0);
    check("unf.addr_const", 32'(ADDR), 32'h02);
    check("unf.flag_const", 32'(STK_UNF), 32'h1);

    // Conditional call/return with false condition are plain SEQ
    step("ccall_n", 1, 1, 5, 8'h90, 8'h00, 2, 1);
    step("cret_n",  1, 1, 6, 0, 8'hFF, 2, 0);
    step("ccall_t", 1, 1, 5, 8'h90, 8'h04, 2, 1);
    step("cret_t",  1, 1, 6, 0, 8'hFB, 2, 0);

    // Wrap
    step("jmpff", 1, 1, 1, 8'hFF, 0, 0, 0);
    step("wrap",  1, 1, 0, 0, 0, 0, 0);
    check("wrap.addr_const", 32'(ADDR), 32'h00);

    // Stall, halt, reset mid-sequence
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 1, 8'h33, 0, 0, 0);
    step("halt",   1, 1, 7, 0, 0, 0, 0);
    step("halted", 1, 1, 1, 8'h33, 0, 0, 0);
    check("halted.flag_const", 32'(HALTED), 32'h1);
    step("rst_mid", 0, 1, 1, 8'h33, 0, 0, 0);
    check("rst_mid.halted_const", 32'(HALTED), 32'h0);

    // Randomized steps
    for (int i = 0; i < 600; i++) begin
      bit rn, en;
      int op;
      rn = ($urandom_range(0, 59) != 0);
      en = ($urandom_range(0, 9) != 0);
      op = ($urandom_range(0, 24) == 0) ? 7 : $urandom_range(0, 6);
      step("rand", rn, en, op, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
